pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Issue/hazard controller that sequences the EX datapath in the 5-stage RV32I core.
//  Takes decoded instructions from ID and drives dp_ctrl, forward_ctrl1 and forward_ctrl2 each EX cycle.
//  Tracks in-flight destinations, stalls ID on load-use, redirects fetch to the datapath wr_pc after JAL/JALR/BRANCH, and flushes wrong-path slots.
// PARAMETERS
//  FLUSH_CYCLES  2         ID slots discarded after a redirect (fetch latency); legal range 1..7
//  NOP_OP        7'b0      opcode driven on dp_ctrl for a bubble; datapath holds all registers
// PORTS
//  clk           in   1   core clock, all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  id_valid      in   1   ID holds a decoded instruction
//  id_opcode     in   7   opcode of the ID instruction
//  id_rs1        in   5   source register 1
//  id_rs2        in   5   source register 2
//  id_rd         in   5   destination register
//  id_ready      out  1   combinational; 1 = ID instruction is consumed at this posedge
//  dp_ctrl       out  7   registered opcode to the datapath for the current EX cycle
//  forward_ctrl1 out  2   registered; 00 = regfile, 01 = wr_data (EX-1), 10 = mem_forward (EX-2)
//  forward_ctrl2 out  2   same encoding as forward_ctrl1, for rs2
//  pc_redirect   out  1   registered 1-cycle pulse; fetch loads PC from datapath wr_pc
//  flush         out  1   registered; high while ID slots are discarded
// BEHAVIOUR
//  Reset (asynchronous): dp_ctrl = NOP_OP, forward_ctrl* = 00, pc_redirect = 0, flush = 0.
//  Reset also clears both tracking slots (EX1, EX2) to invalid, the flush counter to 0, and state to RUN.
//  Tracking slots:
//   - EX1 = {op, rd, valid} of the instruction currently in EX; EX2 = the instruction before it.
//   - Every posedge shifts EX1 -> EX2 and loads EX1 with the issued instruction or a bubble.
//   - A slot writes a register only if op is LUI, AUIPC, JAL, JALR, LOAD, OP_IMM or OP, and rd != 0.
//  Forwarding, computed at issue and registered with dp_ctrl (valid during the consumer's EX):
//   - rsN == 0 gives 00.
//   - rsN matching the EX1 slot gives 01; EX1 wins over EX2 when both match.
//   - rsN matching the EX2 slot gives 10.
//   - Otherwise 00. Forwarding is computed for rs2 regardless of opcode.
//  Load-use: id_ready = 0 when EX1 is a LOAD writer and id_rs1 or id_rs2 equals its rd (rs != 0).
//   - A bubble is issued for one cycle; on the next issue the load sits in EX2 and forwards 10.
//  FSM, states RUN / REDIRECT / FLUSH:
//   - RUN: if id_valid and id_ready, issue the ID instruction; otherwise issue a bubble.
//     If the issued op is JAL, JALR or BRANCH (1100011), go to REDIRECT.
//   - REDIRECT (1 cycle): pc_redirect = 1 and flush = 1. Issue a bubble, load the counter with FLUSH_CYCLES-1.
//     Go to FLUSH if FLUSH_CYCLES > 1, else go to RUN.
//   - FLUSH: flush = 1, bubbles only, decrement the counter, return to RUN when it reaches 0.
//  id_ready is 1 whenever state != RUN; the wrong-path ID instruction is consumed and dropped.
//  Branches always redirect; the datapath writes PC+4 to wr_pc when a branch is not taken.
//  A load-use stall in the same cycle as a branch issue cannot occur: the branch issues, so no stall is raised.
//  Stall has lower priority than redirect/flush.
//  A bubble sets dp_ctrl = NOP_OP and forward_ctrl* = 00.
//  Reset in mid-REDIRECT or mid-FLUSH aborts immediately: state goes to RUN and no pc_redirect pulse follows.
//  id_valid = 0 issues a bubble; the tracking slots still shift.
// TESTING
//  1. ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back -> in ADD's EX: dp_ctrl = 0110011, forward_ctrl1 = forward_ctrl2 = 01.
//  2. ADDI x1; NOP; ADD x3,x1,x0 -> forward_ctrl1 = 10, forward_ctrl2 = 00.
//     ADDI x1; ADDI x1; ADD x3,x1,x0 -> forward_ctrl1 = 01 (nearest wins).
//  3. LW x5,0(x2) then ADDI x6,x5,1 -> id_ready low for exactly 1 cycle.
//     dp_ctrl = 0000000 that cycle, then 0010011 with forward_ctrl1 = 10.
//  4. BEQ then any op, FLUSH_CYCLES = 2 -> cycle after BEQ's EX: pc_redirect = 1 for 1 cycle.
//     flush = 1 for 2 cycles, dp_ctrl = NOP_OP for 2 cycles, then normal issue resumes.
//  5. ADDI x0,x0,1 then ADD x4,x0,x0; also any rs = 0 after a writer -> forward_ctrl* = 00.
//     SW x1,0(x2) writer does not forward to a later reader of x1.
//  6. rst asserted in FLUSH state -> all outputs at reset values in the same cycle; first post-reset issue has forward_ctrl* = 00.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Issue-side bundle between the ID stage and the EX hazard controller.
interface pipe_hazard_ctrl_if;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_ready;
  logic [6:0] dp_ctrl;
  logic [1:0] forward_ctrl1;
  logic [1:0] forward_ctrl2;
  logic       pc_redirect;
  logic       flush;

  // ID stage / fetch side
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd,
    input  id_ready, dp_ctrl, forward_ctrl1, forward_ctrl2, pc_redirect, flush
  );

  // hazard controller side
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd,
    output id_ready, dp_ctrl, forward_ctrl1, forward_ctrl2, pc_redirect, flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller for the EX stage of the 5-stage RV32I core:
// tracks the two in-flight destinations, selects forwarding, stalls on
// load-use and flushes wrong-path ID slots after every control transfer.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [6:0]  NOP_OP       = 7'b0
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] flush_cnt;

  logic       ex1_valid, ex2_valid;
  logic [6:0] ex1_op, ex2_op;
  logic [4:0] ex1_rd, ex2_rd;

  logic       ex1_wr, ex2_wr;
  logic       load_use;
  logic       issue;
  logic       ctrl_xfer;
  logic [1:0] fwd1, fwd2;

  function automatic logic writes_reg(input logic v, input logic [6:0] op,
                                      input logic [4:0] rd);
    return v && (rd != 5'd0) &&
           (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG});
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic w1, input logic [4:0] rd1,
                                         input logic w2, input logic [4:0] rd2);
    if (rs == 5'd0)             return 2'b00;
    else if (w1 && (rd1 == rs)) return 2'b01;
    else if (w2 && (rd2 == rs)) return 2'b10;
    else                        return 2'b00;
  endfunction

  // Hazard detection, issue decision and forwarding select for the ID instruction
  always_comb begin
    ex1_wr    = writes_reg(ex1_valid, ex1_op, ex1_rd);
    ex2_wr    = writes_reg(ex2_valid, ex2_op, ex2_rd);
    load_use  = ex1_wr && (ex1_op == OP_LOAD) &&
                (((bus.id_rs1 != 5'd0) && (bus.id_rs1 == ex1_rd)) ||
                 ((bus.id_rs2 != 5'd0) && (bus.id_rs2 == ex1_rd)));
    // Outside RUN the ID slot is wrong-path: always consume it so it drains.
    bus.id_ready = (state != ST_RUN) || !load_use;
    issue     = (state == ST_RUN) && bus.id_valid && !load_use;
    ctrl_xfer = bus.id_opcode inside {OP_JAL, OP_JALR, OP_BRANCH};
    fwd1      = fwd_sel(bus.id_rs1, ex1_wr, ex1_rd, ex2_wr, ex2_rd);
    fwd2      = fwd_sel(bus.id_rs2, ex1_wr, ex1_rd, ex2_wr, ex2_rd);
  end

  // Tracking slots shift every cycle; EX1 takes the issued instruction or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex1_valid <= 1'b0;
      ex1_op    <= NOP_OP;
      ex1_rd    <= '0;
      ex2_valid <= 1'b0;
      ex2_op    <= NOP_OP;
      ex2_rd    <= '0;
    end else begin
      ex2_valid <= ex1_valid;
      ex2_op    <= ex1_op;
      ex2_rd    <= ex1_rd;
      ex1_valid <= issue;
      ex1_op    <= issue ? bus.id_opcode : NOP_OP;
      ex1_rd    <= issue ? bus.id_rd : '0;
    end
  end

  // Registered EX-cycle controls; a bubble drives NOP_OP with regfile operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dp_ctrl       <= NOP_OP;
      bus.forward_ctrl1 <= 2'b00;
      bus.forward_ctrl2 <= 2'b00;
      bus.pc_redirect   <= 1'b0;
      bus.flush         <= 1'b0;
    end else begin
      bus.dp_ctrl       <= issue ? bus.id_opcode : NOP_OP;
      bus.forward_ctrl1 <= issue ? fwd1 : 2'b00;
      bus.forward_ctrl2 <= issue ? fwd2 : 2'b00;
      bus.pc_redirect   <= (state == ST_REDIRECT);
      bus.flush         <= (state != ST_RUN);
    end
  end

  // RUN/REDIRECT/FLUSH sequencing; REDIRECT counts as the first flushed slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (issue && ctrl_xfer) state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          flush_cnt <= FLUSH_LOAD;
          state     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: scripted instruction streams with
// hand-derived EX-cycle expectations queued at drive time.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] STO = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] NOP = 7'b0000000;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if io();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .NOP_OP(7'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [12:0] sb[$];
  instr_t      plan_st[$];
  logic [12:0] plan_ex[$];
  logic        plan_rdy[$];

  localparam instr_t IDLE = '0;

  function automatic instr_t mk(logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    instr_t s;
    s.v = 1'b1; s.op = op; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    return s;
  endfunction

  // {dp_ctrl, forward_ctrl1, forward_ctrl2, pc_redirect, flush}
  function automatic logic [12:0] ex(logic [6:0] dp, logic [1:0] f1, logic [1:0] f2,
                                     logic rd, logic fl);
    return {dp, f1, f2, rd, fl};
  endfunction

  function automatic logic [12:0] outs();
    return {io.dp_ctrl, io.forward_ctrl1, io.forward_ctrl2, io.pc_redirect, io.flush};
  endfunction

  task automatic plan(instr_t s, logic [12:0] e, logic r);
    plan_st.push_back(s);
    plan_ex.push_back(e);
    plan_rdy.push_back(r);
  endtask

  task automatic drive(instr_t s);
    io.id_valid  = s.v;
    io.id_opcode = s.op;
    io.id_rs1    = s.rs1;
    io.id_rs2    = s.rs2;
    io.id_rd     = s.rd;
  endtask

  task automatic plan_idle2();
    plan(IDLE, ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(IDLE, ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
  endtask

  task automatic test_reset();
    drive(IDLE);
    rst = 1'b1;
    #3;
    n_checks++;
    if (outs() !== ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0))
      $display("FAIL reset_outs: got %h want %h", outs(), ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
    else n_pass++;
    n_checks++;
    if (io.id_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", io.id_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    // EX1 forwarding on both operands
    plan_idle2();
    plan(mk(OPI, 5'd0, 5'd0, 5'd1), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd1, 5'd1, 5'd2), ex(OPR, 2'b01, 2'b01, 1'b0, 1'b0), 1'b1);
    // EX2 forwarding across a bubble
    plan_idle2();
    plan(mk(OPI, 5'd0, 5'd0, 5'd1), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(IDLE,                      ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd1, 5'd0, 5'd3), ex(OPR, 2'b10, 2'b00, 1'b0, 1'b0), 1'b1);
    // nearest producer wins; rs2 field forwards even on an immediate op
    plan_idle2();
    plan(mk(OPI, 5'd0, 5'd0, 5'd1), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPI, 5'd0, 5'd1, 5'd1), ex(OPI, 2'b00, 2'b01, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd1, 5'd0, 5'd3), ex(OPR, 2'b01, 2'b00, 1'b0, 1'b0), 1'b1);
    while (plan_st.size() > 0) begin
      instr_t s; logic r; logic [12:0] got, want;
      s = plan_st.pop_front(); r = plan_rdy.pop_front();
      drive(s); sb.push_back(plan_ex.pop_front());
      #1;
      n_checks++;
      if (io.id_ready !== r) $display("FAIL fwd_ready: got %b want %b", io.id_ready, r);
      else n_pass++;
      @(posedge clk); #1;
      got = outs(); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL fwd_ex: got %h want %h", got, want);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    plan_idle2();
    plan(mk(LD,  5'd2, 5'd0, 5'd5), ex(LD,  2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPI, 5'd5, 5'd0, 5'd6), ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b0);
    plan(mk(OPI, 5'd5, 5'd0, 5'd6), ex(OPI, 2'b10, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(IDLE,                      ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    while (plan_st.size() > 0) begin
      instr_t s; logic r; logic [12:0] got, want;
      s = plan_st.pop_front(); r = plan_rdy.pop_front();
      drive(s); sb.push_back(plan_ex.pop_front());
      #1;
      n_checks++;
      if (io.id_ready !== r) $display("FAIL lu_ready: got %b want %b", io.id_ready, r);
      else n_pass++;
      @(posedge clk); #1;
      got = outs(); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL lu_ex: got %h want %h", got, want);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    plan_idle2();
    plan(mk(BR,  5'd1, 5'd2, 5'd8), ex(BR,  2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd8, 5'd8, 5'd7), ex(NOP, 2'b00, 2'b00, 1'b1, 1'b1), 1'b1);
    plan(mk(OPR, 5'd8, 5'd8, 5'd7), ex(NOP, 2'b00, 2'b00, 1'b0, 1'b1), 1'b1);
    plan(mk(OPR, 5'd8, 5'd8, 5'd7), ex(OPR, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(IDLE,                      ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    while (plan_st.size() > 0) begin
      instr_t s; logic r; logic [12:0] got, want;
      s = plan_st.pop_front(); r = plan_rdy.pop_front();
      drive(s); sb.push_back(plan_ex.pop_front());
      #1;
      n_checks++;
      if (io.id_ready !== r) $display("FAIL redir_ready: got %b want %b", io.id_ready, r);
      else n_pass++;
      @(posedge clk); #1;
      got = outs(); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL redir_ex: got %h want %h", got, want);
      else n_pass++;
    end
  endtask

  task automatic test_zero_store();
    plan_idle2();
    plan(mk(OPI, 5'd0, 5'd0, 5'd0), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd0, 5'd0, 5'd4), ex(OPR, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPI, 5'd0, 5'd0, 5'd1), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd0, 5'd0, 5'd5), ex(OPR, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    // store reads x1 from EX2, but its own rd field must never forward
    plan(mk(STO, 5'd2, 5'd1, 5'd1), ex(STO, 2'b00, 2'b10, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd1, 5'd1, 5'd6), ex(OPR, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    while (plan_st.size() > 0) begin
      instr_t s; logic r; logic [12:0] got, want;
      s = plan_st.pop_front(); r = plan_rdy.pop_front();
      drive(s); sb.push_back(plan_ex.pop_front());
      #1;
      n_checks++;
      if (io.id_ready !== r) $display("FAIL zero_ready: got %b want %b", io.id_ready, r);
      else n_pass++;
      @(posedge clk); #1;
      got = outs(); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL zero_ex: got %h want %h", got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_flush();
    logic [12:0] got, want;
    plan_idle2();
    plan(mk(OPI, 5'd0, 5'd0, 5'd1), ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(BR,  5'd1, 5'd0, 5'd0), ex(BR,  2'b01, 2'b00, 1'b0, 1'b0), 1'b1);
    plan(mk(OPR, 5'd1, 5'd1, 5'd9), ex(NOP, 2'b00, 2'b00, 1'b1, 1'b1), 1'b1);
    while (plan_st.size() > 0) begin
      instr_t s; logic r;
      s = plan_st.pop_front(); r = plan_rdy.pop_front();
      drive(s); sb.push_back(plan_ex.pop_front());
      #1;
      n_checks++;
      if (io.id_ready !== r) $display("FAIL rf_ready: got %b want %b", io.id_ready, r);
      else n_pass++;
      @(posedge clk); #1;
      got = outs(); want = sb.pop_front();
      n_checks++;
      if (got !== want) $display("FAIL rf_ex: got %h want %h", got, want);
      else n_pass++;
    end
    // now in FLUSH: asynchronous reset must clear outputs without a clock edge
    drive(mk(OPR, 5'd1, 5'd1, 5'd9));
    #1;
    rst = 1'b1;
    #1;
    want = ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0);
    n_checks++;
    if (outs() !== want) $display("FAIL rf_async: got %h want %h", outs(), want);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    drive(IDLE);
    sb.push_back(ex(NOP, 2'b00, 2'b00, 1'b0, 1'b0));
    @(posedge clk); #1;
    got = outs(); want = sb.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rf_no_pulse: got %h want %h", got, want);
    else n_pass++;
    // a writer left in EX1 must be forgotten across reset
    drive(mk(OPI, 5'd0, 5'd0, 5'd1));
    sb.push_back(ex(OPI, 2'b00, 2'b00, 1'b0, 1'b0));
    @(posedge clk); #1;
    got = outs(); want = sb.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rf_pre: got %h want %h", got, want);
    else n_pass++;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(mk(OPR, 5'd1, 5'd1, 5'd3));
    sb.push_back(ex(OPR, 2'b00, 2'b00, 1'b0, 1'b0));
    @(posedge clk); #1;
    got = outs(); want = sb.pop_front();
    n_checks++;
    if (got !== want) $display("FAIL rf_first_issue: got %h want %h", got, want);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_zero_store();
    test_reset_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
